// File: rtl/sdram_pkg.sv
// Shared encodings for the sdram_model behavioural SDRAM device:
// command codes, device states, error codes, mode-word fields and burst helpers.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_IDLE     = 2'd1,
        ST_RD_BURST = 2'd2,
        ST_WR_BURST = 2'd3
    } dev_state_e;

    localparam logic [3:0] ERR_NONE       = 4'd0;
    localparam logic [3:0] ERR_ACT_ACTIVE = 4'd1;
    localparam logic [3:0] ERR_RW_IDLE    = 4'd2;
    localparam logic [3:0] ERR_REF_ACTIVE = 4'd3;
    localparam logic [3:0] ERR_INIT_CMD   = 4'd4;
    localparam logic [3:0] ERR_TRCD       = 4'd5;
    localparam logic [3:0] ERR_TRP        = 4'd6;

    localparam int MODE_BL_LSB  = 0;
    localparam int MODE_BL_MSB  = 2;
    localparam int MODE_CAS_LSB = 4;
    localparam int MODE_CAS_MSB = 6;
    localparam int AP_BIT       = 10;

    // Burst length field 0..3 -> length-1 mask for 1,2,4,8 beats.
    function automatic logic [2:0] bl_mask(input logic [1:0] code);
        case (code)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            2'd2:    return 3'd3;
            2'd3:    return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    // Sequential wrap inside the burst-length-aligned block.
    function automatic logic [7:0] burst_col(input logic [7:0] start, input logic [2:0] beat,
                                             input logic [2:0] blm1);
        logic [7:0] mask;
        mask = {5'd0, blm1};
        return (start & ~mask) | ((start + {5'd0, beat}) & mask);
    endfunction

    // Byte-masked write merge: a set mask bit keeps the old byte.
    function automatic logic [15:0] apply_dqm(input logic [15:0] old_word, input logic [15:0] new_word,
                                              input logic [1:0] dqm);
        return {dqm[1] ? old_word[15:8] : new_word[15:8],
                dqm[0] ? old_word[7:0]  : new_word[7:0]};
    endfunction

endpackage

// File: rtl/sdram_model_bank.sv
// One SDRAM bank: open-row tracking and, with SDRAM_MODEL_TIMING_CHECK_EN defined,
// tRCD/tRP cycle counters.
module sdram_model_bank #(
    parameter int TRCD_CYC = 2,
    parameter int TRP_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cke,
    input  logic        act,
    input  logic        pre,
    input  logic [11:0] row_in,
    output logic        active,
    output logic [11:0] row,
    output logic        rcd_ok,
    output logic        rp_ok
);

    logic        active_r;
    logic [11:0] row_r;

    // Bank open/closed state and the row latched by ACTIVE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_r <= 1'b0;
            row_r    <= 12'd0;
        end else if (cke) begin
            if (act) begin
                active_r <= 1'b1;
                row_r    <= row_in;
            end else if (pre) begin
                active_r <= 1'b0;
            end
        end
    end

    assign active = active_r;
    assign row    = row_r;

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
    localparam int CW = 4;
    localparam logic [CW-1:0] RCD_LOAD = (TRCD_CYC > 32'sd1) ? CW'(TRCD_CYC - 32'sd1) : {CW{1'b0}};
    localparam logic [CW-1:0] RP_LOAD  = (TRP_CYC  > 32'sd1) ? CW'(TRP_CYC  - 32'sd1) : {CW{1'b0}};

    logic [CW-1:0] rcd_cnt_r;
    logic [CW-1:0] rp_cnt_r;

    // Countdown from ACTIVE / closing PRECHARGE; zero means the next command is legal
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcd_cnt_r <= {CW{1'b0}};
            rp_cnt_r  <= {CW{1'b0}};
        end else if (cke) begin
            if (act)
                rcd_cnt_r <= RCD_LOAD;
            else if (rcd_cnt_r != {CW{1'b0}})
                rcd_cnt_r <= rcd_cnt_r - {{(CW-1){1'b0}}, 1'b1};
            if (pre && active_r)
                rp_cnt_r <= RP_LOAD;
            else if (rp_cnt_r != {CW{1'b0}})
                rp_cnt_r <= rp_cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign rcd_ok = (rcd_cnt_r == {CW{1'b0}});
    assign rp_ok  = (rp_cnt_r  == {CW{1'b0}});
`else
    // No timing enforcement: any legal (non-negative) setting accepts every command
    assign rcd_ok = (TRCD_CYC >= 32'sd0);
    assign rp_ok  = (TRP_CYC  >= 32'sd0);
`endif

endmodule

// File: rtl/sdram_model.sv
// sdram_model: behavioural 4-bank x16 SDRAM device with protocol-error flagging.
// Build option: define SDRAM_MODEL_TIMING_CHECK_EN to enforce tRCD/tRP (codes 5/6).
module sdram_model #(
    parameter int CAS_DEF  = 2,
    parameter int MEM_AW   = 10,
    parameter int TRCD_CYC = 2,
    parameter int TRP_CYC  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cke,
    input  logic        i_csn,
    input  logic        i_rasn,
    input  logic        i_casn,
    input  logic        i_wen,
    input  logic [1:0]  i_ba,
    input  logic [11:0] i_addr,
    input  logic [1:0]  i_dqm,
    input  logic [15:0] i_dq,
    output logic [15:0] o_dq,
    output logic        o_dq_oe,
    output logic        o_err,
    output logic [3:0]  o_err_code
);
    import sdram_pkg::*;

    localparam int MEM_WORDS = 32'd1 << MEM_AW;

    logic [15:0] mem_r [MEM_WORDS];

    dev_state_e  state_r;
    logic        cas3_r;
    logic [2:0]  blm1_r;
    logic        bst_act_r, bst_rd_r, bst_ap_r;
    logic [1:0]  bst_ba_r;
    logic [11:0] bst_row_r;
    logic [7:0]  bst_col_r;
    logic [2:0]  bst_beat_r, bst_blm1_r;
    logic        p1_v_r, p2_v_r;
    logic [15:0] p1_d_r, p2_d_r;

    cmd_e        cmd_s;
    logic        err_s, new_rw_s, lmr_s, bst_cmd_s, stop_s, cont_s;
    logic [3:0]  err_code_s;
    logic [3:0]  bank_act_s, cmd_pre_s, close_s, bank_pre_s, bank_active_s, rcd_ok_s, rp_ok_s;
    logic [11:0] bank_row_s [4];
    logic        iss_v_s, iss_rd_s, iss_ap_s, iss_last_s;
    logic [1:0]  iss_ba_s;
    logic [11:0] iss_row_s;
    logic [7:0]  iss_start_s, iss_col_s;
    logic [2:0]  iss_beat_s, iss_blm1_s;
    logic [MEM_AW-1:0] mem_idx_s;
    logic [15:0] rd_word_s, wr_word_s;

    for (genvar b = 0; b < 4; b++) begin : g_bank
        sdram_model_bank #(.TRCD_CYC(TRCD_CYC), .TRP_CYC(TRP_CYC)) u_bank (
            .clk    (i_clk),
            .rst    (i_rst),
            .cke    (i_cke),
            .act    (bank_act_s[b]),
            .pre    (bank_pre_s[b]),
            .row_in (i_addr),
            .active (bank_active_s[b]),
            .row    (bank_row_s[b]),
            .rcd_ok (rcd_ok_s[b]),
            .rp_ok  (rp_ok_s[b])
        );
    end

    // Pin decode; a deselected chip behaves as NOP
    always_comb begin
        if (i_csn) cmd_s = CMD_NOP;
        else       cmd_s = cmd_e'({i_rasn, i_casn, i_wen});
    end

    // Protocol checks; a violating command is flagged and otherwise ignored
    always_comb begin
        err_s      = 1'b0;
        err_code_s = ERR_NONE;
        new_rw_s   = 1'b0;
        lmr_s      = 1'b0;
        bst_cmd_s  = 1'b0;
        bank_act_s = 4'b0000;
        cmd_pre_s  = 4'b0000;
        if (i_cke) begin
            case (cmd_s)
                CMD_ACT: begin
                    if (state_r == ST_INIT) begin
                        err_s = 1'b1; err_code_s = ERR_INIT_CMD;
                    end else if (bank_active_s[i_ba]) begin
                        err_s = 1'b1; err_code_s = ERR_ACT_ACTIVE;
                    end else if (!rp_ok_s[i_ba]) begin
                        err_s = 1'b1; err_code_s = ERR_TRP;
                    end else begin
                        bank_act_s[i_ba] = 1'b1;
                    end
                end
                CMD_RD, CMD_WR: begin
                    if (state_r == ST_INIT) begin
                        err_s = 1'b1; err_code_s = ERR_INIT_CMD;
                    end else if (!bank_active_s[i_ba]) begin
                        err_s = 1'b1; err_code_s = ERR_RW_IDLE;
                    end else if (!rcd_ok_s[i_ba]) begin
                        err_s = 1'b1; err_code_s = ERR_TRCD;
                    end else begin
                        new_rw_s = 1'b1;
                    end
                end
                CMD_PRE: begin
                    if (i_addr[AP_BIT]) cmd_pre_s = 4'b1111;
                    else                cmd_pre_s[i_ba] = 1'b1;
                end
                CMD_REF: begin
                    if (|bank_active_s) begin
                        err_s = 1'b1; err_code_s = ERR_REF_ACTIVE;
                    end else begin
                        err_s = 1'b0;
                    end
                end
                CMD_LMR: lmr_s = 1'b1;
                CMD_BST: begin
                    if (state_r == ST_INIT) begin
                        err_s = 1'b1; err_code_s = ERR_INIT_CMD;
                    end else begin
                        bst_cmd_s = 1'b1;
                    end
                end
                default: err_s = 1'b0;
            endcase
        end else begin
            err_s = 1'b0;
        end
    end

    // Beat issue: a new READ/WRITE starts at beat 0, otherwise the open burst continues
    always_comb begin
        stop_s = new_rw_s | bst_cmd_s;
        cont_s = i_cke & bst_act_r & ~stop_s;
        if (new_rw_s) begin
            iss_v_s     = 1'b1;
            iss_rd_s    = (cmd_s == CMD_RD);
            iss_ap_s    = i_addr[AP_BIT];
            iss_ba_s    = i_ba;
            iss_row_s   = bank_row_s[i_ba];
            iss_start_s = i_addr[7:0];
            iss_beat_s  = 3'd0;
            iss_blm1_s  = blm1_r;
        end else if (cont_s) begin
            iss_v_s     = 1'b1;
            iss_rd_s    = bst_rd_r;
            iss_ap_s    = bst_ap_r;
            iss_ba_s    = bst_ba_r;
            iss_row_s   = bst_row_r;
            iss_start_s = bst_col_r;
            iss_beat_s  = bst_beat_r;
            iss_blm1_s  = bst_blm1_r;
        end else begin
            iss_v_s     = 1'b0;
            iss_rd_s    = 1'b0;
            iss_ap_s    = 1'b0;
            iss_ba_s    = 2'd0;
            iss_row_s   = 12'd0;
            iss_start_s = 8'd0;
            iss_beat_s  = 3'd0;
            iss_blm1_s  = 3'd0;
        end
    end

    assign iss_col_s  = burst_col(iss_start_s, iss_beat_s, iss_blm1_s);
    assign iss_last_s = (iss_beat_s == iss_blm1_s);
    assign mem_idx_s  = MEM_AW'({iss_ba_s, iss_row_s, iss_col_s});
    assign rd_word_s  = mem_r[mem_idx_s];
    assign wr_word_s  = apply_dqm(rd_word_s, i_dq, i_dqm);

    // Auto-precharge closes the bank after its last beat, or when its burst is cut short
    assign close_s = ((iss_v_s && iss_last_s && iss_ap_s) ? (4'b0001 << iss_ba_s) : 4'b0000) |
                     ((bst_act_r && bst_ap_r && stop_s)   ? (4'b0001 << bst_ba_r) : 4'b0000);
    assign bank_pre_s = cmd_pre_s | close_s;

    // Storage array, deliberately not reset
    always_ff @(posedge i_clk) begin
        if (i_cke && iss_v_s && !iss_rd_s)
            mem_r[mem_idx_s] <= wr_word_s;
    end

    // Device FSM, mode register, burst tracker, CAS pipeline and error latch
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= ST_INIT;
            cas3_r     <= (CAS_DEF == 32'sd3);
            blm1_r     <= 3'd0;
            bst_act_r  <= 1'b0;
            bst_rd_r   <= 1'b0;
            bst_ap_r   <= 1'b0;
            bst_ba_r   <= 2'd0;
            bst_row_r  <= 12'd0;
            bst_col_r  <= 8'd0;
            bst_beat_r <= 3'd0;
            bst_blm1_r <= 3'd0;
            p1_v_r     <= 1'b0;
            p1_d_r     <= 16'd0;
            p2_v_r     <= 1'b0;
            p2_d_r     <= 16'd0;
            o_dq       <= 16'd0;
            o_dq_oe    <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= 4'd0;
        end else if (i_cke) begin
            if (lmr_s) begin
                if (!i_addr[MODE_BL_MSB])
                    blm1_r <= bl_mask(i_addr[MODE_BL_LSB +: 2]);
                if (i_addr[MODE_CAS_MSB:MODE_CAS_LSB] == 3'd2)
                    cas3_r <= 1'b0;
                else if (i_addr[MODE_CAS_MSB:MODE_CAS_LSB] == 3'd3)
                    cas3_r <= 1'b1;
            end

            if (state_r == ST_INIT) begin
                if (lmr_s && (bank_active_s == 4'b0000))
                    state_r <= ST_IDLE;
            end else if (iss_v_s && !iss_last_s) begin
                state_r <= iss_rd_s ? ST_RD_BURST : ST_WR_BURST;
            end else begin
                state_r <= ST_IDLE;
            end

            if (iss_v_s && !iss_last_s) begin
                bst_act_r  <= 1'b1;
                bst_rd_r   <= iss_rd_s;
                bst_ap_r   <= iss_ap_s;
                bst_ba_r   <= iss_ba_s;
                bst_row_r  <= iss_row_s;
                bst_col_r  <= iss_start_s;
                bst_beat_r <= iss_beat_s + 3'd1;
                bst_blm1_r <= iss_blm1_s;
            end else begin
                bst_act_r  <= 1'b0;
            end

            // Read data is captured at issue, then delayed CAS-1 edges to the pins
            p1_v_r  <= iss_v_s & iss_rd_s;
            p1_d_r  <= (iss_v_s && iss_rd_s) ? rd_word_s : 16'd0;
            p2_v_r  <= p1_v_r;
            p2_d_r  <= p1_d_r;
            o_dq_oe <= cas3_r ? p2_v_r : p1_v_r;
            o_dq    <= cas3_r ? p2_d_r : p1_d_r;

            if (err_s && !o_err) begin
                o_err      <= 1'b1;
                o_err_code <= err_code_s;
            end
        end
    end

endmodule

// File: tb/tb_sdram_model.sv
// Directed self-checking bench for sdram_model (default parameters).
module tb_sdram_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cke = 1'b1;
    logic        csn = 1'b1, rasn = 1'b1, casn = 1'b1, wen = 1'b1;
    logic [1:0]  ba = 2'd0;
    logic [1:0]  dqm = 2'd0;
    logic [11:0] addr = 12'd0;
    logic [15:0] dq_in = 16'd0;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        err;
    logic [3:0]  err_code;

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_BST = 3'b110;
    localparam logic [2:0] C_NOP = 3'b111;

    sdram_model dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cke      (cke),
        .i_csn      (csn),
        .i_rasn     (rasn),
        .i_casn     (casn),
        .i_wen      (wen),
        .i_ba       (ba),
        .i_addr     (addr),
        .i_dqm      (dqm),
        .i_dq       (dq_in),
        .o_dq       (dq_out),
        .o_dq_oe    (dq_oe),
        .o_err      (err),
        .o_err_code (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one command for the next rising edge, return at the following falling edge
    task automatic send(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                        input logic [15:0] d, input logic [1:0] m);
        csn = 1'b0;
        {rasn, casn, wen} = c;
        ba = b; addr = a; dq_in = d; dqm = m;
        @(negedge clk);
    endtask

    task automatic nop();
        send(C_NOP, 2'd0, 12'd0, 16'd0, 2'd0);
    endtask

    task automatic beat(input string tag, input logic [15:0] exp);
        check(tag, {15'd0, dq_oe, dq_out}, {15'd0, 1'b1, exp});
    endtask

    task automatic idle(input string tag);
        check(tag, {31'd0, dq_oe}, 32'd0);
    endtask

    task automatic err_is(input string tag, input logic e, input logic [3:0] code);
        check(tag, {27'd0, err, err_code}, {27'd0, e, code});
    endtask

    initial begin
        @(negedge clk);
        idle("rst_oe");
        check("rst_dq", {16'd0, dq_out}, 32'd0);
        err_is("rst_err", 1'b0, 4'd0);
        rst = 1'b0;

        // READ one cycle after ACTIVE on the same bank
        send(C_LMR, 2'd0, 12'h021, 16'd0, 2'd0);
        nop();
        send(C_ACT, 2'd2, 12'h000, 16'd0, 2'd0);
        send(C_RD,  2'd2, 12'h000, 16'd0, 2'd0);
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
        err_is("trcd_err", 1'b1, 4'd5);
`else
        err_is("trcd_err", 1'b0, 4'd0);
`endif
        nop(); nop(); nop();
        rst = 1'b1;
        @(negedge clk);
        err_is("rst2_err", 1'b0, 4'd0);
        rst = 1'b0;

        // CAS2 BL2 write then read
        send(C_LMR, 2'd0, 12'h021, 16'd0, 2'd0);
        nop();
        send(C_ACT, 2'd0, 12'h005, 16'd0, 2'd0);
        nop(); nop();
        send(C_WR,  2'd0, 12'h004, 16'hBEEF, 2'b00);
        send(C_NOP, 2'd0, 12'h000, 16'h1234, 2'b00);
        send(C_RD,  2'd0, 12'h004, 16'd0, 2'd0);
        idle("cas2_n0");
        nop(); beat("cas2_b0", 16'hBEEF);
        nop(); beat("cas2_b1", 16'h1234);
        nop(); idle("cas2_end");

        // Byte masks on both beats
        send(C_WR,  2'd0, 12'h008, 16'h5555, 2'b00);
        send(C_NOP, 2'd0, 12'h000, 16'h0000, 2'b00);
        send(C_WR,  2'd0, 12'h008, 16'hAAAA, 2'b10);
        send(C_NOP, 2'd0, 12'h000, 16'hFFFF, 2'b01);
        send(C_RD,  2'd0, 12'h008, 16'd0, 2'd0);
        nop(); beat("dqm_hi", 16'h55AA);
        nop(); beat("dqm_lo", 16'hFF00);
        nop();

        // BL4 CAS3 with column wrap
        send(C_LMR, 2'd0, 12'h032, 16'd0, 2'd0);
        send(C_WR,  2'd0, 12'h004, 16'hC004, 2'd0);
        send(C_NOP, 2'd0, 12'h000, 16'hC005, 2'd0);
        send(C_NOP, 2'd0, 12'h000, 16'hC006, 2'd0);
        send(C_NOP, 2'd0, 12'h000, 16'hC007, 2'd0);
        send(C_RD,  2'd0, 12'h006, 16'd0, 2'd0);
        idle("cas3_n0");
        nop(); idle("cas3_n1");
        nop(); beat("wrap_c6", 16'hC006);
        nop(); beat("wrap_c7", 16'hC007);
        nop(); beat("wrap_c4", 16'hC004);
        nop(); beat("wrap_c5", 16'hC005);
        nop(); idle("wrap_end");

        // BURST TERMINATE one edge after READ leaves a single beat
        send(C_RD,  2'd0, 12'h004, 16'd0, 2'd0);
        send(C_BST, 2'd0, 12'h000, 16'd0, 2'd0);
        idle("bst_n1");
        nop(); beat("bst_b0", 16'hC004);
        nop(); idle("bst_cut");
        nop(); nop();

        // First error sticks
        send(C_RD,  2'd1, 12'h000, 16'd0, 2'd0);
        err_is("rw_idle", 1'b1, 4'd2);
        send(C_ACT, 2'd0, 12'h005, 16'd0, 2'd0);
        err_is("first_kept", 1'b1, 4'd2);
        nop(); nop();

        // Asynchronous reset in the middle of a BL8 read
        send(C_LMR, 2'd0, 12'h033, 16'd0, 2'd0);
        send(C_RD,  2'd0, 12'h004, 16'd0, 2'd0);
        nop(); nop();
        beat("bl8_b0", 16'hC004);
        #2 rst = 1'b1;
        #1 idle("rst_async_oe");
        err_is("rst_async_err", 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back in INIT: ACTIVE is rejected, then re-init and read old data
        send(C_ACT, 2'd0, 12'h005, 16'd0, 2'd0);
        err_is("init_cmd", 1'b1, 4'd4);
        send(C_LMR, 2'd0, 12'h021, 16'd0, 2'd0);
        nop();
        send(C_ACT, 2'd0, 12'h005, 16'd0, 2'd0);
        nop(); nop();
        send(C_RD,  2'd0, 12'h008, 16'd0, 2'd0);
        nop(); beat("keep_b0", 16'h55AA);
        nop(); beat("keep_b1", 16'hFF00);
        nop();
        err_is("init_err_kept", 1'b1, 4'd4);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_model.md
SDRAM_MODEL -- requirements
Module: sdram_model

Interface
REQ-001 Parameter CAS_DEF, default 2: CAS latency used until the first LOAD MODE; legal values 2 or 3.
REQ-002 Parameter MEM_AW, default 10: log2 of the number of stored 16-bit words; storage address is the low MEM_AW bits of {ba,row,col}.
REQ-003 Parameter TRCD_CYC, default 2: minimum cycles from ACTIVE to READ/WRITE on the same bank.
REQ-004 Parameter TRP_CYC, default 2: minimum cycles from PRECHARGE to ACTIVE on the same bank.
REQ-005 i_clk  in  1: single clock; controller pins are sampled on its rising edge.
REQ-006 i_rst  in  1: reset, asynchronous, active-high.
REQ-007 i_cke  in  1: clock enable; low freezes all state and ignores commands.
REQ-008 i_csn, i_rasn, i_casn, i_wen  in  1 each: command pins, active-low.
REQ-009 i_ba  in  2: bank address.
REQ-010 i_addr  in  12: row (ACTIVE), column [7:0] plus auto-precharge bit [10] (READ/WRITE), mode word (LOAD MODE).
REQ-011 i_dqm  in  2: write byte mask; bit1 masks [15:8], bit0 masks [7:0]; zero latency.
REQ-012 i_dq  in  16: write data.
REQ-013 o_dq  out  16: read data; o_dq_oe  out  1: read data valid/drive enable.
REQ-014 o_err  out  1: sticky protocol-violation flag; o_err_code  out  4: code of the first violation.

Function
REQ-015 Decode when i_cke=1: csn=1 or {ras,cas,we}=111 NOP; 011 ACTIVE; 101 READ; 100 WRITE; 010 PRECHARGE (A10=1: all banks); 001 AUTO REFRESH; 000 LOAD MODE; 110 BURST TERMINATE.
REQ-016 Each bank tracks IDLE/ACTIVE and open row; ACTIVE opens, PRECHARGE closes; READ/WRITE with A10=1 closes the bank after its final burst beat.
REQ-017 LOAD MODE: burst length from addr[2:0] (0..3 gives 1,2,4,8); CAS from addr[6:4]; all other bits ignored.
REQ-018 Device states INIT, IDLE, RD_BURST, WR_BURST; INIT to IDLE on first LOAD MODE with all banks IDLE; any command other than NOP, PRECHARGE, AUTO REFRESH, LOAD MODE in INIT is an error and is otherwise ignored.
REQ-019 WRITE at edge N stores i_dq beat 0 at edge N, beat k at edge N+k; bytes with i_dqm bit set keep old value.
REQ-020 READ at edge N: beat k on o_dq with o_dq_oe=1 in the cycle after edge N+CAS-1+k; o_dq_oe=0 otherwise.
REQ-021 Burst columns wrap sequentially inside the BL-aligned block (BL=4 from col 6: 6,7,4,5).
REQ-022 New READ/WRITE during a burst truncates the old burst at that edge; already-scheduled read beats of the old burst are still delivered; BURST TERMINATE stops further beats.
REQ-023 Error codes: 1 ACTIVE to ACTIVE bank; 2 READ/WRITE to IDLE bank; 3 AUTO REFRESH with any bank ACTIVE; 4 command in INIT; 5 tRCD; 6 tRP; only the first error is latched.

Reset
REQ-024 i_rst forces: all banks IDLE, state INIT, CAS=CAS_DEF, BL=1, o_dq=0, o_dq_oe=0, o_err=0, o_err_code=0, pipelines flushed; memory contents are not cleared.
REQ-025 Reset asserted mid-burst deasserts o_dq_oe immediately (asynchronously).

Configuration
REQ-026 Macro SDRAM_MODEL_TIMING_CHECK_EN defined: per-bank cycle counters enforce TRCD_CYC/TRP_CYC and raise codes 5/6; not defined: counters absent, codes 5/6 never raised, commands accepted with no timing check.

Structure
REQ-027 Package sdram_pkg holds command encodings, device-state enum, error-code constants and mode-field positions.
REQ-028 Sub-module sdram_model_bank, instanced four times: open-row/state tracking, auto-precharge, optional timing counters.

Verification
REQ-029 Reset, LOAD MODE 0x021 (CAS2, BL2), ACTIVE b0 row 5, WRITE col 4 data 0xBEEF,0x1234 -> READ col 4 at edge N yields 0xBEEF after edge N+1, 0x1234 after N+2.
REQ-030 WRITE 0xAAAA over 0x5555 with i_dqm=2'b10 -> readback 0x55AA.
REQ-031 LOAD MODE BL4 CAS3, READ col 6 -> beats in column order 6,7,4,5 starting after edge N+2.
REQ-032 READ to IDLE bank 1 -> o_err=1, o_err_code=2; later ACTIVE-on-ACTIVE error leaves code 2.
REQ-033 i_rst pulse during BL8 read -> o_dq_oe=0 at once, state INIT, prior written data intact after re-init.
REQ-034 With SDRAM_MODEL_TIMING_CHECK_EN and TRCD_CYC=2, READ one cycle after ACTIVE -> o_err_code=5; without macro -> o_err stays 0.
